// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU step controller: FSM encoding and parameter defaults.
package cpu_step_ctrl_pkg;

    localparam int unsigned DEB_CYCLES_DEF = 1000000;
    localparam int unsigned CNT_W_DEF      = 32;

    typedef enum logic [1:0] {
        PAUSED   = 2'd0,
        RUNNING  = 2'd1,
        STEPPING = 2'd2
    } step_state_e;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Pushbutton debouncer: synchronise, require DEB_CYCLES stable samples, emit a press pulse.
module btn_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync_q;
    logic          stable;
    logic          armed;
    logic [CW-1:0] cnt;
    logic          accept_c;

    // Synced level has differed from the stable level long enough to be accepted.
    assign accept_c = (sync_q != stable) && (cnt == CW'(DEB_CYCLES - 1));

    // Synchroniser, debounce counter and press pulse. A button must be seen
    // released after reset (armed) before a press can be reported, so a
    // button held through reset never fires.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1  <= 1'b0;
            sync_q <= 1'b0;
            stable <= 1'b0;
            armed  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1  <= btn_raw;
            sync_q <= sync1;
            if (sync_q == stable) begin
                cnt <= '0;
            end else if (accept_c) begin
                cnt    <= '0;
                stable <= sync_q;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (!sync_q && !stable) begin
                armed <= 1'b1;
            end
            press <= accept_c && sync_q && armed;
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns the slow divider clock and run/pause/step buttons into a one-cycle CPU enable.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             slow_clk,
    input  logic             btn_run,
    input  logic             btn_pause,
    input  logic             btn_step,
    output logic             cpu_en,
    output logic             running,
    output logic [CNT_W-1:0] step_count
);

    logic        slow_s1;
    logic        slow_sync_q;
    logic        slow_edge_q;
    logic        tick_c;
    logic        run_press;
    logic        pause_press;
    logic        step_press;
    step_state_e state_q;
    step_state_e state_d;
    logic        issue_c;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .btn_raw (btn_run),
        .press   (run_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .btn_raw (btn_pause),
        .press   (pause_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .btn_raw (btn_step),
        .press   (step_press)
    );

    // Two-flop synchroniser plus edge register for the asynchronous slow clock.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slow_s1     <= 1'b0;
            slow_sync_q <= 1'b0;
            slow_edge_q <= 1'b0;
        end else begin
            slow_s1     <= slow_clk;
            slow_sync_q <= slow_s1;
            slow_edge_q <= slow_sync_q;
        end
    end

    // Rising edges only; falling edges of slow_clk are ignored.
    assign tick_c = slow_sync_q & ~slow_edge_q;

    // Next-state and issue decision; pause beats run beats step. The step
    // pulse is decided on entry so cpu_en is high during the STEPPING cycle.
    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        case (state_q)
            PAUSED: begin
                if (pause_press) begin
                    state_d = PAUSED;
                end else if (run_press) begin
                    state_d = RUNNING;
                end else if (step_press) begin
                    state_d = STEPPING;
                    issue_c = 1'b1;
                end
            end
            RUNNING: begin
                if (pause_press) begin
                    state_d = PAUSED;
                end else if (tick_c) begin
                    issue_c = 1'b1;
                end
            end
            STEPPING: begin
                state_d = PAUSED;
            end
            default: begin
                state_d = PAUSED;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= PAUSED;
            cpu_en     <= 1'b0;
            running    <= 1'b0;
            step_count <= '0;
        end else begin
            state_q    <= state_d;
            cpu_en     <= issue_c;
            running    <= (state_d == RUNNING);
            step_count <= step_count + CNT_W'(cpu_en);
        end
    end

endmodule
